// File: rtl/clk_div_prog_pkg.sv
// Shared constants and types for the programmable clock divider.
// Optional build macro: CLK_DIV_PCNT_EN (adds the period counter output).
package clk_div_pkg;

  localparam int MIN_DIV         = 2;
  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 4;

  typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle between a divider client and clk_div_prog.
// Optional build macro: CLK_DIV_PCNT_EN (adds period_cnt to the bundle).
interface clk_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_cur;
`ifdef CLK_DIV_PCNT_EN
  logic [15:0]      period_cnt;

  modport master (
    output en, div_in, div_load,
    input  div_ack, div_err, clk_out, tick, div_cur, period_cnt
  );

  modport slave (
    input  en, div_in, div_load,
    output div_ack, div_err, clk_out, tick, div_cur, period_cnt
  );
`else
  modport master (
    output en, div_in, div_load,
    input  div_ack, div_err, clk_out, tick, div_cur
  );

  modport slave (
    input  en, div_in, div_load,
    output div_ack, div_err, clk_out, tick, div_cur
  );
`endif

endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: registered clk_out/tick, glitch-free divisor reload.
// Optional build macro: CLK_DIV_PCNT_EN (period counter, cleared on each divisor ack).
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_prog_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_q,    pend_d;
  logic             pend_v_q,  pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q,    tick_d;
  logic             ack_q,     ack_d;
  logic             err_q,     err_d;

  logic wrap;
  logic load_bad;
  logic load_ok;
  logic apply;

  always_comb begin
    wrap     = bus.en && (cnt_q == div_cur_q - ONE);
    load_bad = bus.div_load && (bus.div_in < MIN_W);
    load_ok  = bus.div_load && !load_bad;
    // A pending divisor only takes over at a period boundary, or at once when idle.
    apply    = pend_v_q && (!bus.en || wrap);

    cnt_d = '0;
    if (bus.en && !wrap) begin
      cnt_d = cnt_q + ONE;
    end

    div_cur_d = apply ? pend_q : div_cur_q;
    pend_d    = load_ok ? bus.div_in : pend_q;
    pend_v_d  = load_ok || (pend_v_q && !apply);
    ack_d     = apply;
    err_d     = load_bad;

    // Outputs are registered views of the next count against the next divisor.
    clk_out_d = (cnt_d >= (div_cur_d >> 1));
    tick_d    = (cnt_d == div_cur_d - ONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      div_cur_q <= DEF_DIV;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.div_ack = ack_q;
  assign bus.div_err = err_q;
  assign bus.div_cur = div_cur_q;

`ifdef CLK_DIV_PCNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (ack_d) begin
      pcnt_d = '0;
    end else if (tick_q) begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign bus.period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed vector table, corner sequences, random run vs model.
module tb_clk_div_prog;
  import clk_div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clk_div_prog_if #(.CNT_W(CNT_W_DEF)) bus ();

  clk_div_prog #(.CNT_W(CNT_W_DEF), .DEFAULT_DIV(DEFAULT_DIV_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: position in period, active divisor, at most one pending divisor.
  int m_cnt;
  int m_d;
  int m_pend[$];
  bit m_ack;
  bit m_err;

  typedef struct {
    bit en; bit ld; int din;
    bit clk_o; bit tick; bit ack; bit err; int cur;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit ld, int din, bit c, bit t, bit a, bit e, int cur);
    vec_t v;
    v.en = en; v.ld = ld; v.din = din;
    v.clk_o = c; v.tick = t; v.ack = a; v.err = e; v.cur = cur;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_d   = DEFAULT_DIV_DEF;
    m_pend.delete();
    m_ack = 0;
    m_err = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int din);
    bit at_end;
    at_end = en && (m_cnt == m_d - 1);
    m_ack = 0;
    m_err = 0;
    if (m_pend.size() != 0 && (!en || at_end)) begin
      m_d   = m_pend.pop_front();
      m_ack = 1;
    end
    if (ld) begin
      if (din < MIN_DIV) m_err = 1;
      else begin
        m_pend.delete();
        m_pend.push_back(din);
      end
    end
    m_cnt = (!en || at_end) ? 0 : m_cnt + 1;
  endtask

  task automatic cycle(input bit en, input bit ld, input int din);
    bus.en       = en;
    bus.div_load = ld;
    bus.div_in   = div_t'(din);
    @(posedge clk);
    model_step(en, ld, din);
    #1;
    check("clk_out", int'(bus.clk_out), int'(m_cnt >= m_d / 2));
    check("tick",    int'(bus.tick),    int'(m_cnt == m_d - 1));
    check("div_ack", int'(bus.div_ack), int'(m_ack));
    check("div_err", int'(bus.div_err), int'(m_err));
    check("div_cur", int'(bus.div_cur), m_d);
    bus.div_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk_out"}, int'(bus.clk_out), 0);
    check({tag, "_tick"},    int'(bus.tick),    0);
    check({tag, "_ack"},     int'(bus.div_ack), 0);
    check({tag, "_err"},     int'(bus.div_err), 0);
    check({tag, "_cur"},     int'(bus.div_cur), 4);
  endtask

  initial begin
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
    model_reset();

    // Default D=4, load 5 at cnt=1, rejects, 6-then-8, load in wrap cycle.
    tbl.push_back(mk(1,0,0, 0,0,0,0,4));
    tbl.push_back(mk(1,1,5, 1,0,0,0,4));
    tbl.push_back(mk(1,0,0, 1,1,0,0,4));
    tbl.push_back(mk(1,0,0, 0,0,1,0,5));
    tbl.push_back(mk(1,0,0, 0,0,0,0,5));
    tbl.push_back(mk(1,0,0, 1,0,0,0,5));
    tbl.push_back(mk(1,0,0, 1,0,0,0,5));
    tbl.push_back(mk(1,0,0, 1,1,0,0,5));
    tbl.push_back(mk(1,0,0, 0,0,0,0,5));
    tbl.push_back(mk(1,1,1, 0,0,0,1,5));
    tbl.push_back(mk(1,0,0, 1,0,0,0,5));
    tbl.push_back(mk(1,1,0, 1,0,0,1,5));
    tbl.push_back(mk(1,0,0, 1,1,0,0,5));
    tbl.push_back(mk(1,0,0, 0,0,0,0,5));
    tbl.push_back(mk(1,1,6, 0,0,0,0,5));
    tbl.push_back(mk(1,1,8, 1,0,0,0,5));
    tbl.push_back(mk(1,0,0, 1,0,0,0,5));
    tbl.push_back(mk(1,0,0, 1,1,0,0,5));
    tbl.push_back(mk(1,0,0, 0,0,1,0,8));
    tbl.push_back(mk(1,0,0, 0,0,0,0,8));
    tbl.push_back(mk(1,0,0, 0,0,0,0,8));
    tbl.push_back(mk(1,0,0, 0,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,1,0,0,8));
    tbl.push_back(mk(1,1,3, 0,0,0,0,8));
    tbl.push_back(mk(1,0,0, 0,0,0,0,8));
    tbl.push_back(mk(1,0,0, 0,0,0,0,8));
    tbl.push_back(mk(1,0,0, 0,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,0,0,0,8));
    tbl.push_back(mk(1,0,0, 1,1,0,0,8));
    tbl.push_back(mk(1,0,0, 0,0,1,0,3));
    tbl.push_back(mk(1,0,0, 1,0,0,0,3));
    tbl.push_back(mk(1,0,0, 1,1,0,0,3));
    tbl.push_back(mk(1,0,0, 0,0,0,0,3));

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].ld, tbl[i].din);
      check($sformatf("tbl%0d_clk_out", i), int'(bus.clk_out), int'(tbl[i].clk_o));
      check($sformatf("tbl%0d_tick", i),    int'(bus.tick),    int'(tbl[i].tick));
      check($sformatf("tbl%0d_ack", i),     int'(bus.div_ack), int'(tbl[i].ack));
      check($sformatf("tbl%0d_err", i),     int'(bus.div_err), int'(tbl[i].err));
      check($sformatf("tbl%0d_cur", i),     int'(bus.div_cur), tbl[i].cur);
    end

    // Idle load: applied on the very next edge.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    cycle(0, 1, 3);
    check("idle_store_ack", int'(bus.div_ack), 0);
    check("idle_store_cur", int'(bus.div_cur), 4);
    cycle(0, 0, 0);
    check("idle_apply_ack", int'(bus.div_ack), 1);
    check("idle_apply_cur", int'(bus.div_cur), 3);
    cycle(0, 0, 0);
    check("idle_ack_pulse", int'(bus.div_ack), 0);

    // Asynchronous reset mid-period with a pending load discards it.
    cycle(1, 0, 0);
    cycle(1, 1, 7);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, 0, 0);
      check($sformatf("post_rst%0d_noack", i), int'(bus.div_ack), 0);
      check($sformatf("post_rst%0d_cur", i),   int'(bus.div_cur), 4);
    end

    // Random run against the model.
    for (int i = 0; i < 500; i++) begin
      bit en_r, ld_r;
      int din_r;
      en_r  = ($urandom_range(0, 9) != 0);
      ld_r  = ($urandom_range(0, 7) == 0);
      din_r = int'($urandom_range(0, 11));
      cycle(en_r, ld_r, din_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable clock divider for the fabric clock domain. It produces a divided clock-enable waveform `clk_out` and a one-cycle `tick` strobe per output period. The divisor is configurable at build time through width and default, and can be changed at run time through a glitch-free load/ack handshake. Downstream display and scan logic consume `tick` or `clk_out` in place of fixed divide-by-4 logic.

Parameters:
CNT_W, 16, width of the divisor and of the internal counter.
DEFAULT_DIV, 4, divisor active after reset. Must be at least 2 and at most 2^CNT_W-1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `en`  in  1  divider run enable.
- `div_in`  in  CNT_W  requested divisor.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_ack`  out  1  one-cycle pulse when the requested divisor becomes active.
- `div_err`  out  1  one-cycle pulse when a load is rejected.
- `clk_out`  out  1  divided waveform (registered).
- `tick`  out  1  one-cycle pulse in the last cycle of each output period.
- `div_cur`  out  CNT_W  divisor currently in use.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - `cnt`=0, `clk_out`=0, `tick`=0, `div_ack`=0, `div_err`=0.
  - `div_cur`=DEFAULT_DIV; pending-valid flag cleared.
- Divisor D = `div_cur`. While `en`=1, `cnt` counts 0..D-1, then wraps to 0.
- `clk_out` is a register that always satisfies `clk_out` == (`cnt` >= D>>1).
  - Output period is D cycles; low for floor(D/2) cycles, high for ceil(D/2) cycles.
  - Example, D=4: `cnt` 0,1 → low; `cnt` 2,3 → high (50% duty). Odd D gives the extra cycle to the high phase.
- `tick` is registered and equals (`cnt` == D-1); it is high in exactly one cycle per period.
- `en`=0: `cnt` is held at 0, so `clk_out`=0 and `tick`=0. The next `en` rise starts at `cnt`=0 with no partial period.
- Load handshake, when `div_load`=1:
  - `div_in` < 2: not stored. `div_err` pulses in the next cycle; `div_cur` and any pending value are unchanged.
  - Otherwise: `div_in` is stored as pending and the pending-valid flag is set. A second load before application overwrites it (last wins), and only one `div_ack` is issued.
- Pending value is applied:
  - with `en`=1: at the wrap edge (`cnt`==D-1 → 0). `div_cur` updates on that edge and `div_ack` pulses in the same cycle that `div_cur` first shows the new value.
  - with `en`=0: on the first edge after it was stored, with `div_ack` at the same time.
- A load in the wrap cycle itself is applied at the wrap edge of the following period, so the new D is never used mid-period.
- No glitches: `clk_out` changes only at the D>>1 crossing and at the wrap, for both the old and new D.
- Width: `cnt` is CNT_W bits. D-1 and D>>1 are computed at CNT_W width; no overflow occurs for D ≤ 2^CNT_W-1.
- Reset mid-operation aborts everything: any pending load is discarded and no ack is issued.

Optional Feature:
CLK_DIV_PCNT_EN
- Defined: adds output `period_cnt` [15:0]. It is reset to 0, increments on every `tick`, and wraps 0xFFFF → 0. It is cleared when `div_ack` pulses.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package `clk_div_pkg` holds:
  - localparam MIN_DIV=2;
  - the CNT_W default (16) and DEFAULT_DIV default (4);
  - typedef `div_t` = logic [CNT_W-1:0].
- Single flat module; the reload logic is too small to justify a sub-module.

Test Plan:
- Reset, then `en`=1 with default D=4 → `clk_out` 0,0,1,1 repeating; `tick` in every 4th cycle; `div_cur`=4.
- Load `div_in`=5 while `cnt`=1 → no change until the wrap. Then `div_cur`=5 and `div_ack` for one cycle; `clk_out` 0,0,1,1,1; `tick` every 5 cycles.
- Load `div_in`=1 and, separately, `div_in`=0 → `div_err` pulses each time; `div_cur` stays unchanged; no `div_ack`.
- Load 6 then 8 within one period → single `div_ack` at the wrap, `div_cur`=8.
- Load in the wrap cycle (`cnt`=D-1) → applied one full period later.
- `en`=0 with a pending load of 3 → `div_ack` on the next edge. Assert `rst`=0 mid-period with a pending load → all outputs 0, `div_cur`=4, no ack after release.
